mul_signed_pipe_3: RTL and testbench

MUL_SIGNED_PIPE_3 -- requirements
Module: mul_signed_pipe_3

---
 rtl/fft_3_pkg.sv | 40 ++++
 rtl/smul_stage_3.sv | 36 +++
 rtl/mul_signed_pipe_3.sv | 105 ++++++++++
 tb/tb_mul_signed_pipe_3.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fft_3_pkg.sv
// Shared widths, limits and the per-stage pipeline record for the signed Q1.7 multiplier.
// Helper functions take two's-complement inputs to unsigned magnitudes without losing the most-negative value.
package fft_3_pkg;

    localparam int A_W         = 16;
    localparam int B_W         = 8;
    localparam int ACC_W       = 25;
    localparam int Q_SHIFT_DEF = 7;
    localparam int PIPE_LAT    = 10;
    localparam int N_SA        = 8;

    localparam logic [ACC_W-1:0] POS_LIM = 25'd32767;
    localparam logic [ACC_W-1:0] NEG_LIM = 25'd32768;
    localparam logic [A_W-1:0]   SAT_MAX = 16'h7FFF;
    localparam logic [A_W-1:0]   SAT_MIN = 16'h8000;

    typedef struct packed {
        logic             vld;
        logic             sign;
        logic [ACC_W-1:0] mcand;
        logic [B_W-1:0]   mplier;
        logic [ACC_W-1:0] psum;
    } sa_t;

    function automatic logic [A_W:0] mag_a(input logic [A_W-1:0] x);
        logic [A_W:0] ext;
        ext = {x[A_W-1], x};
        return x[A_W-1] ? (~ext + 1'b1) : ext;
    endfunction

    // Computed one bit wider so -128 lands on 128 before the top bit is dropped.
    function automatic logic [B_W-1:0] mag_b(input logic [B_W-1:0] x);
        logic [B_W:0] ext;
        logic [B_W:0] mag;
        ext = {x[B_W-1], x};
        mag = x[B_W-1] ? (~ext + 1'b1) : ext;
        return mag[B_W-1:0];
    endfunction

endpackage

// File: rtl/smul_stage_3.sv
// One shift-add step: adds the multiplicand when the multiplier LSB is set, then shifts both.
// Latency 1 cycle; en=0 holds every field, flush (with en) clears the valid bit.
// No backpressure beyond the global en hold.
module smul_stage_3
    import fft_3_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic flush,
    input  sa_t  st_i,
    output sa_t  st_o
);

    sa_t st_d;
    sa_t st_q;

    always_comb begin
        st_d        = st_i;
        st_d.vld    = st_i.vld & ~flush;
        st_d.psum   = st_i.mplier[0] ? (st_i.psum + st_i.mcand) : st_i.psum;
        st_d.mcand  = st_i.mcand << 1;
        st_d.mplier = st_i.mplier >> 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= '0;
        end else if (en) begin
            st_q <= st_d;
        end
    end

    assign st_o = st_q;

endmodule

// File: rtl/mul_signed_pipe_3.sv
// Signed 16x8 (Q1.7) multiplier, sign/magnitude front end, 8 shift-add steps, saturating back end.
// Latency 10 advancing cycles, one sample per cycle.
// No backpressure: en=0 freezes the whole pipe, flush drops everything in flight.
module mul_signed_pipe_3
    import fft_3_pkg::*;
#(
    parameter int Q_SHIFT = Q_SHIFT_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           flush,
    input  logic           in_valid,
    input  logic [A_W-1:0] a_in,
    input  logic [B_W-1:0] b_in,
    output logic           out_valid,
    output logic [A_W-1:0] p_out,
    output logic           ovf
);

    sa_t s0_d;
    sa_t s0_q;
    sa_t chain [0:N_SA];

    always_comb begin
        s0_d        = '0;
        s0_d.vld    = in_valid & ~flush;
        s0_d.sign   = a_in[A_W-1] ^ b_in[B_W-1];
        s0_d.mcand  = ACC_W'(mag_a(a_in));
        s0_d.mplier = mag_b(b_in);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q <= '0;
        end else if (en) begin
            s0_q <= s0_d;
        end
    end

    assign chain[0] = s0_q;

    for (genvar g = 0; g < N_SA; g++) begin : g_sa
        smul_stage_3 u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .flush (flush),
            .st_i  (chain[g]),
            .st_o  (chain[g+1])
        );
    end

    // Final multiplicand/multiplier residues carry no information past the last step.
    logic unused_tail;
    assign unused_tail = ^{chain[N_SA].mcand, chain[N_SA].mplier};

    logic [ACC_W-1:0] m;
    logic [ACC_W-1:0] neg_m;
    logic             out_valid_d, out_valid_q;
    logic [A_W-1:0]   p_out_d, p_out_q;
    logic             ovf_d, ovf_q;

    always_comb begin
        m           = chain[N_SA].psum >> Q_SHIFT;
        neg_m       = ~m + 1'b1;
        out_valid_d = chain[N_SA].vld & ~flush;
        p_out_d     = '0;
        ovf_d       = 1'b0;
        if (out_valid_d) begin
            if (!chain[N_SA].sign) begin
                if (m > POS_LIM) begin
                    p_out_d = SAT_MAX;
                    ovf_d   = 1'b1;
                end else begin
                    p_out_d = m[A_W-1:0];
                end
            end else begin
                if (m > NEG_LIM) begin
                    p_out_d = SAT_MIN;
                    ovf_d   = 1'b1;
                end else begin
                    p_out_d = neg_m[A_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            p_out_q     <= '0;
            ovf_q       <= 1'b0;
        end else if (en) begin
            out_valid_q <= out_valid_d;
            p_out_q     <= p_out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign p_out     = p_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mul_signed_pipe_3.sv
// Directed and randomized bench for mul_signed_pipe_3 with a plain-arithmetic reference model.
module tb_mul_signed_pipe_3;

    localparam int Q = 7;
    localparam int LAT = 10;

    typedef struct {
        logic [15:0] p;
        logic        o;
        int          c;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic        in_valid;
    logic [15:0] a_in;
    logic [7:0]  b_in;
    logic        out_valid;
    logic [15:0] p_out;
    logic        ovf;

    int   checks = 0;
    int   errors = 0;
    int   adv    = 0;
    int   n_out  = 0;
    exp_t sb [$];
    logic        prev_vld;
    logic [15:0] prev_p;
    logic        prev_o;

    mul_signed_pipe_3 #(.Q_SHIFT(Q)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .p_out     (p_out),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: exact product, magnitude truncated by the Q shift, then clipped to 16 bits.
    function automatic exp_t model(input logic signed [15:0] a, input logic signed [7:0] b);
        exp_t e;
        int prod, mag, r;
        prod = int'(a) * int'(b);
        mag  = (prod < 0 ? -prod : prod) >> Q;
        r    = (prod < 0) ? -mag : mag;
        e.c  = 0;
        if (r > 32767) begin
            e.p = 16'h7FFF; e.o = 1'b1;
        end else if (r < -32768) begin
            e.p = 16'h8000; e.o = 1'b1;
        end else begin
            e.p = 16'(r); e.o = 1'b0;
        end
        return e;
    endfunction

    task automatic step(input logic v, input logic [15:0] a, input logic [7:0] b,
                        input logic e, input logic f, input logic use_exp,
                        input logic [15:0] xp, input logic xo);
        exp_t ent;
        in_valid = v; a_in = a; b_in = b; en = e; flush = f;
        ent = model(a, b);
        if (use_exp) begin
            ent.p = xp; ent.o = xo;
        end
        ent.c = adv;
        @(posedge clk);
        #1;
        if (e) begin
            adv++;
            if (f) sb.delete();
            else if (v) sb.push_back(ent);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_vld", 32'(out_valid), 32'd0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    n_out++;
                    chk("p_out", 32'(p_out), 32'(x.p));
                    chk("ovf", 32'(ovf), 32'(x.o));
                    chk("latency", 32'(adv - x.c), 32'(LAT));
                end
            end else begin
                chk("idle_p", 32'(p_out), 32'd0);
                chk("idle_ovf", 32'(ovf), 32'd0);
            end
        end else begin
            chk("hold_vld", 32'(out_valid), 32'(prev_vld));
            chk("hold_p", 32'(p_out), 32'(prev_p));
            chk("hold_ovf", 32'(ovf), 32'(prev_o));
        end
        prev_vld = out_valid; prev_p = p_out; prev_o = ovf;
    endtask

    task automatic rnd(input logic e, input logic f);
        step(1'b1, 16'($urandom), 8'($urandom), e, f, 1'b0, 16'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'd0, 8'd0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0;
        #2;
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_p", 32'(p_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_vld = 1'b0; prev_p = '0; prev_o = 1'b0;

        // Directed corner products, back to back.
        step(1'b1, 16'd100,   8'd64,   1'b1, 1'b0, 1'b1, 16'd50,    1'b0);
        step(1'b1, 16'hFED4,  8'd127,  1'b1, 1'b0, 1'b1, 16'hFED7,  1'b0);
        step(1'b1, 16'h8000,  8'h80,   1'b1, 1'b0, 1'b1, 16'h7FFF,  1'b1);
        step(1'b1, 16'h7FFF,  8'h80,   1'b1, 1'b0, 1'b1, 16'h8001,  1'b0);
        step(1'b1, 16'h8000,  8'h00,   1'b1, 1'b0, 1'b1, 16'h0000,  1'b0);
        idle(LAT + 2);
        chk("directed_drained", 32'(sb.size()), 32'd0);
        chk("directed_count", 32'(n_out), 32'd5);

        // Random stream with a 3-cycle stall; flush during the stall is ignored.
        n_out = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                for (int k = 0; k < 3; k++) rnd(1'b0, 1'b1);
            end
            rnd(1'b1, 1'b0);
        end
        idle(LAT + 2);
        chk("stream_drained", 32'(sb.size()), 32'd0);
        chk("stream_count", 32'(n_out), 32'd20);

        // Flush at the sixth sample of a 10-sample burst.
        n_out = 0;
        for (int i = 0; i < 10; i++) rnd(1'b1, i == 5);
        idle(LAT + 2);
        chk("flush_drained", 32'(sb.size()), 32'd0);
        chk("flush_count", 32'(n_out), 32'd4);

        // Reset mid-stream with outputs active.
        for (int i = 0; i < 12; i++) rnd(1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(out_valid), 32'd0);
        chk("arst_p", 32'(p_out), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("in_rst_vld", 32'(out_valid), 32'd0);
        end
        rst_n = 1'b1;
        sb.delete();
        prev_vld = 1'b0; prev_p = '0; prev_o = 1'b0;
        n_out = 0;
        idle(LAT + 3);
        chk("no_stale", 32'(n_out), 32'd0);
        step(1'b1, 16'd1000, 8'hC0, 1'b1, 1'b0, 1'b1, 16'hFE0C, 1'b0);
        idle(LAT + 1);
        chk("post_rst_count", 32'(n_out), 32'd1);
        chk("post_rst_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
